// File: rtl/dense_transpose_reader.sv
// dense_transpose_reader
//   Streams a transposed weight matrix (ROW_NUM x COL_NUM elements, DENSE_DATA_N
//   elements per word, row-major) out of a 1-cycle-latency RAM towards the
//   backward dense multiplier. Words are buffered in a 2-entry FIFO, so
//   backpressure never loses or duplicates a word.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   run                 level enable; low clears all sequencing state
//   ren, raddr, rdata   RAM read port (rdata valid the cycle after ren)
//   out_valid/ready     output handshake
//   out_data            streamed word (FIFO head)
//   out_row, out_last   row index of out_data, last word of its row
//   done                whole matrix transferred (held while run=1)
//   stall_cnt           only with `DENSE_READER_STALL_CNT_EN: cycles with
//                       out_valid & !out_ready, saturating, cleared by run=0
//
// Optional feature macro: DENSE_READER_STALL_CNT_EN

`ifndef N_LEN
`define N_LEN 16
`endif

module dense_transpose_reader #(
    parameter int unsigned ADDR_WIDTH   = 10,
    parameter int unsigned DENSE_DATA_N = 8,
    parameter int unsigned ROW_NUM      = 32,
    parameter int unsigned COL_NUM      = 24
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           run,
    output logic                           ren,
    output logic [ADDR_WIDTH-1:0]          raddr,
    input  logic [DENSE_DATA_N*`N_LEN-1:0] rdata,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [DENSE_DATA_N*`N_LEN-1:0] out_data,
    output logic [5:0]                     out_row,
    output logic                           out_last,
    output logic                           done
`ifdef DENSE_READER_STALL_CNT_EN
    ,
    output logic [15:0]                    stall_cnt
`endif
);

    localparam int unsigned DW    = DENSE_DATA_N * `N_LEN;
    localparam int unsigned WPR   = COL_NUM / DENSE_DATA_N;
    localparam int unsigned DEPTH = ROW_NUM * WPR;
    localparam int unsigned CNT_W = ADDR_WIDTH + 1;
    localparam int unsigned COL_W = (WPR > 1) ? $clog2(WPR) : 1;

    if (ROW_NUM > 64) begin : g_row_chk
        $error("ROW_NUM must be <= 64 (out_row is 6 bits)");
    end
    if ((COL_NUM % DENSE_DATA_N) != 0) begin : g_col_chk
        $error("COL_NUM must be a multiple of DENSE_DATA_N");
    end
    if (DEPTH > (2 ** ADDR_WIDTH)) begin : g_depth_chk
        $error("matrix does not fit in 2**ADDR_WIDTH words");
    end

    // run_q delays the first read by one cycle after run rises.
    logic             run_q;
    logic [CNT_W-1:0] issued_q;
    logic [COL_W-1:0] iss_col_q;
    logic [5:0]       iss_row_q;
    logic             iss_last;

    // Read in flight: rdata becomes valid this cycle, captured at the next edge.
    logic             pend_q;
    logic [5:0]       pend_row_q;
    logic             pend_last_q;

    logic [DW-1:0]    mem_data_q [2];
    logic [5:0]       mem_row_q  [2];
    logic             mem_last_q [2];
    logic             wr_ptr_q;
    logic             rd_ptr_q;
    logic [1:0]       count_q;

    logic [CNT_W-1:0] xfer_q;
    logic             done_q;
    logic             pop;
    logic [2:0]       occ_next;

    assign out_valid = (count_q != 2'd0);
    assign pop       = out_valid & out_ready;
    assign out_data  = mem_data_q[rd_ptr_q];
    assign out_row   = mem_row_q[rd_ptr_q];
    assign out_last  = mem_last_q[rd_ptr_q];
    assign done      = done_q;
    assign raddr     = issued_q[ADDR_WIDTH-1:0];
    assign iss_last  = (iss_col_q == COL_W'(WPR - 1));

    // Occupancy after this edge, counting the arriving read and this cycle's pop.
    // A new read is allowed only if that leaves a free slot for its data, which
    // keeps full throughput with only two FIFO entries.
    assign occ_next = 3'(count_q) + 3'(pend_q) - 3'(pop);
    assign ren = run & run_q & (issued_q < CNT_W'(DEPTH)) & (occ_next < 3'd2);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q       <= 1'b0;
            issued_q    <= '0;
            iss_col_q   <= '0;
            iss_row_q   <= '0;
            pend_q      <= 1'b0;
            pend_row_q  <= '0;
            pend_last_q <= 1'b0;
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            count_q     <= '0;
            xfer_q      <= '0;
            done_q      <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                mem_data_q[i] <= '0;
                mem_row_q[i]  <= '0;
                mem_last_q[i] <= 1'b0;
            end
        end else if (!run) begin
            // Clearing pend_q discards any read still in flight.
            run_q    <= 1'b0;
            issued_q <= '0;
            iss_col_q <= '0;
            iss_row_q <= '0;
            pend_q   <= 1'b0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= '0;
            xfer_q   <= '0;
            done_q   <= 1'b0;
        end else begin
            run_q  <= 1'b1;
            pend_q <= ren;
            if (ren) begin
                issued_q    <= issued_q + CNT_W'(1);
                pend_row_q  <= iss_row_q;
                pend_last_q <= iss_last;
                if (iss_last) begin
                    iss_col_q <= '0;
                    iss_row_q <= iss_row_q + 6'd1;
                end else begin
                    iss_col_q <= iss_col_q + COL_W'(1);
                end
            end
            if (pend_q) begin
                mem_data_q[wr_ptr_q] <= rdata;
                mem_row_q[wr_ptr_q]  <= pend_row_q;
                mem_last_q[wr_ptr_q] <= pend_last_q;
                wr_ptr_q             <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
                xfer_q   <= xfer_q + CNT_W'(1);
                if (xfer_q == CNT_W'(DEPTH - 1)) begin
                    done_q <= 1'b1;
                end
            end
            count_q <= count_q + {1'b0, pend_q} - {1'b0, pop};
        end
    end

`ifdef DENSE_READER_STALL_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (!run) begin
            stall_cnt <= '0;
        end else if (out_valid && !out_ready && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dense_transpose_reader.sv
// Scoreboard bench for dense_transpose_reader: stimulus pushes the expected
// word sequence when a run starts; a monitor pops and compares on every
// transfer. Directed tests: reset, full stream, backpressure, random ready,
// run drop/restart, async reset mid-stream, optional stall counter.

`ifndef N_LEN
`define N_LEN 16
`endif

module tb_dense_transpose_reader;

    localparam int AW    = 10;
    localparam int DN    = 8;
    localparam int RN    = 32;
    localparam int CN    = 24;
    localparam int NL    = `N_LEN;
    localparam int DW    = DN * NL;
    localparam int WPR   = CN / DN;
    localparam int DEPTH = RN * WPR;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          run = 1'b0;
    logic          out_ready = 1'b0;
    logic          ren;
    logic [AW-1:0] raddr;
    logic [DW-1:0] rdata = '0;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic [5:0]    out_row;
    logic          out_last;
    logic          done;
`ifdef DENSE_READER_STALL_CNT_EN
    logic [15:0]   stall_cnt;
`endif

    dense_transpose_reader #(
        .ADDR_WIDTH  (AW),
        .DENSE_DATA_N(DN),
        .ROW_NUM     (RN),
        .COL_NUM     (CN)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .run      (run),
        .ren      (ren),
        .raddr    (raddr),
        .rdata    (rdata),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_row  (out_row),
        .out_last (out_last),
        .done     (done)
`ifdef DENSE_READER_STALL_CNT_EN
        ,
        .stall_cnt(stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] data;
        logic [5:0]    row;
        logic          last;
        int            idx;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   xfers  = 0;

    function automatic logic [DW-1:0] word(input int k);
        logic [NL-1:0] e;
        e = NL'(k);
        return {DN{e}};
    endfunction

    // 1-cycle-latency RAM: word k holds k replicated.
    always @(posedge clk) begin
        if (ren) rdata <= word(int'(raddr));
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_data(input string name, input logic [DW-1:0] act,
                            input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_stream();
        for (int k = 0; k < DEPTH; k++) begin
            sb.push_back('{word(k), 6'(k / WPR), (k % WPR) == WPR - 1, k});
        end
    endtask

    // Monitor: every transfer pops the scoreboard; a stalled word must stay put.
    exp_t          mon_e;
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_data = '0;
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_underflow: got word %0h expected none", out_data);
                end else begin
                    mon_e = sb.pop_front();
                    chk_data("out_data", out_data, mon_e.data);
                    chk("out_row", 32'(out_row), 32'(mon_e.row));
                    chk("out_last", 32'(out_last), 32'(mon_e.last));
                    if (mon_e.idx != DEPTH - 1) chk("done_early", 32'(done), 32'd0);
                end
                xfers++;
            end
            if (prev_stall && out_valid) chk_data("hold_stable", out_data, prev_data);
            prev_stall = run && out_valid && !out_ready;
            prev_data  = out_data;
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic stop_run();
        step();
        run = 1'b0;
        step();
        sb.delete();
        chk("stop_valid", 32'(out_valid), 32'd0);
        chk("stop_done", 32'(done), 32'd0);
    endtask

    task automatic wait_done(input string name, input int base);
        int n = 0;
        while (!done && n < 600) begin
            step();
            n++;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got done=0 expected done=1", name);
        end
        chk({name, "_xfers"}, 32'(xfers - base), 32'(DEPTH));
        chk({name, "_sb_empty"}, 32'(sb.size()), 32'd0);
    endtask

    task automatic wait_head(input string name, input int k);
        int n = 0;
        while (!(out_valid && out_data == word(k)) && n < 300) begin
            step();
            n++;
        end
        chk({name, "_head_found"}, 32'(out_valid && out_data == word(k)), 32'd1);
    endtask

    initial begin
        int base;
        int n;
        logic primed;

        // Reset state
        repeat (2) step();
        chk("rst_ren", 32'(ren), 32'd0);
        chk("rst_raddr", 32'(raddr), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk_data("rst_data", out_data, '0);
        chk("rst_row", 32'(out_row), 32'd0);
        chk("rst_last", 32'(out_last), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
`ifdef DENSE_READER_STALL_CNT_EN
        chk("rst_stall_cnt", 32'(stall_cnt), 32'd0);
`endif
        rst_n = 1'b1;
        step();

        // Full stream, ready held high: latency and cycle count
        base = xfers;
        push_stream();
        out_ready = 1'b1;
        run = 1'b1;
        step();
        chk("lat_ren_e0", 32'(ren), 32'd1);
        chk("lat_raddr_e0", 32'(raddr), 32'd0);
        step();
        chk("lat_valid_e1", 32'(out_valid), 32'd0);
        step();
        chk("lat_valid_e2", 32'(out_valid), 32'd1);
        chk_data("lat_data_e2", out_data, word(0));
        n = 3;
        while (!done && n < 600) begin
            step();
            n++;
        end
        chk("full_edges_to_done", 32'(n), 32'(DEPTH + 3));
        chk("full_xfers", 32'(xfers - base), 32'(DEPTH));
        chk("full_sb_empty", 32'(sb.size()), 32'd0);
        repeat (2) step();
        chk("full_done_held", 32'(done), 32'd1);
        chk("full_ren_after_done", 32'(ren), 32'd0);

        // Backpressure: ready low for 10 cycles with word 5 at the head
        stop_run();
        base = xfers;
        push_stream();
        run = 1'b1;
        wait_head("bp", 5);
        out_ready = 1'b0;
        #1;
        for (int i = 0; i < 10; i++) begin
            chk("bp_ren_stalled", 32'(ren), 32'd0);
            chk_data("bp_data_stalled", out_data, word(5));
            step();
        end
        out_ready = 1'b1;
        wait_done("bp", base);

        // Random ready over 3 runs: once primed, no bubble while ready is high
        for (int r = 0; r < 3; r++) begin
            stop_run();
            base = xfers;
            push_stream();
            run = 1'b1;
            primed = 1'b0;
            n = 0;
            while (!done && n < 2000) begin
                step();
                out_ready = 1'($urandom_range(0, 1));
                #1;
                if (primed && (xfers - base) < DEPTH && out_ready)
                    chk("rnd_no_bubble", 32'(out_valid), 32'd1);
                if (out_valid) primed = 1'b1;
                n++;
            end
            out_ready = 1'b1;
            wait_done("rnd", base);
        end

        // run dropped at word 40, reasserted 3 cycles later
        stop_run();
        push_stream();
        run = 1'b1;
        wait_head("drop", 40);
        run = 1'b0;
        step();
        sb.delete();
        chk("drop_valid", 32'(out_valid), 32'd0);
        chk("drop_done", 32'(done), 32'd0);
        chk("drop_raddr", 32'(raddr), 32'd0);
        repeat (2) step();
        base = xfers;
        push_stream();
        run = 1'b1;
        step();
        chk("restart_ren", 32'(ren), 32'd1);
        chk("restart_raddr", 32'(raddr), 32'd0);
        wait_done("restart", base);

        // Asynchronous reset between edges in the middle of a stream
        stop_run();
        push_stream();
        run = 1'b1;
        repeat (20) step();
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_ren", 32'(ren), 32'd0);
        chk("arst_raddr", 32'(raddr), 32'd0);
        chk("arst_valid", 32'(out_valid), 32'd0);
        chk_data("arst_data", out_data, '0);
        chk("arst_row", 32'(out_row), 32'd0);
        chk("arst_last", 32'(out_last), 32'd0);
        chk("arst_done", 32'(done), 32'd0);
        sb.delete();
        push_stream();
        step();
        base = xfers;
        rst_n = 1'b1;
        wait_done("arst", base);

`ifdef DENSE_READER_STALL_CNT_EN
        // Stall counter: 7 stalled cycles, then cleared by run low
        stop_run();
        chk("stall_cnt_clear0", 32'(stall_cnt), 32'd0);
        push_stream();
        run = 1'b1;
        wait_head("stall", 0);
        out_ready = 1'b0;
        repeat (7) step();
        chk("stall_cnt_7", 32'(stall_cnt), 32'd7);
        out_ready = 1'b1;
        stop_run();
        chk("stall_cnt_cleared", 32'(stall_cnt), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish expected finish before 2 ms");
        $fatal(1);
    end

endmodule
